uart_line_rx: RTL
=================

# uart_line_rx

Receive-side line assembler for the board UART: consumes the byte stream from `uart_rx` and collects printable bytes into a line buffer until CR or LF. It compares the finished line against a parameterised expected string, which defaults to the banner the board itself transmits. It then presents the line to a downstream consumer (command logic, loopback checker) through a valid/ack handshake with random read access. It sits between `uart_rx` and any host-command logic in the top level.

## Interface
- `CLK_FRE`, 27: clock frequency in MHz.
- `TIMEOUT_MS`, 1000: inter-byte timeout in ms. Timeout cycles = CLK_FRE*1000*TIMEOUT_MS, held in a 32-bit counter.
- `MAX_LEN`, 32: line buffer depth in bytes, 2..255.
- `EXP_LEN`, 18: expected string length in bytes, 1..MAX_LEN.
- `EXP_STR`, "Hello Tang Nano 9K": expected string, EXP_LEN*8 bits, first character in the MSBs.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: byte from `uart_rx`.
- `rx_data_valid` in 1: byte available.
- `rx_data_ready` out 1: block can accept a byte.
- `line_valid` out 1: a complete line is held.
- `line_len` out 8: number of bytes in the held line. Terminator is excluded.
- `line_match` out 1: held line equals EXP_STR exactly.
- `rd_addr` in $clog2(MAX_LEN): byte index to read.
- `rd_data` out 8: buffer byte at `rd_addr`, registered.
- `line_ack` in 1: consumer releases the line.
- `overflow` out 1: one-cycle pulse when a line is discarded for length.
- `timeout` out 1: one-cycle pulse when a partial line is discarded for inactivity.

## Operation
- A byte is accepted when `rx_data_valid` and `rx_data_ready` are both 1. Only accepted bytes count.
- States:
  - IDLE
  - COLLECT
  - HOLD
  - DISCARD
- IDLE:
  - CR (0x0D) or LF (0x0A) is dropped, so empty lines and the LF of a CR-LF pair are swallowed.
  - Any other byte is written at index 0, len becomes 1, and the state goes to COLLECT.
- COLLECT:
  - CR or LF → HOLD.
  - Other byte with len < MAX_LEN: written at index len, len increments.
  - Other byte with len == MAX_LEN: pulse `overflow`, go to DISCARD.
- DISCARD: bytes are dropped. CR or LF → IDLE, len cleared.
- HOLD:
  - `line_valid`=1, `rx_data_ready`=0. This backpressures `uart_rx`.
  - `line_ack`=1 → IDLE next cycle, `line_valid`=0, len cleared.
  - `line_ack` outside HOLD is ignored.
- Match tracking:
  - A `match_ok` flag is set on the first byte of a line.
  - It is cleared when a byte at index i ≥ EXP_LEN is written, or when the written byte differs from EXP_STR byte i.
  - `line_match` = `match_ok` && len == EXP_LEN. It is registered on HOLD entry and is 0 outside HOLD.
- Timeout:
  - Applies in COLLECT and DISCARD.
  - The counter increments every cycle with no accepted byte and clears on every accepted byte.
  - When it reaches the limit: pulse `timeout`, go to IDLE, clear len.
  - The counter is held at 0 in IDLE and HOLD.
- Reads: `rd_data` = buffer[`rd_addr`] when `rd_addr` < `line_len`, else 0x00. Valid in any state; defined as stable only in HOLD.

## Timing
- Reset values:
  - `rx_data_ready`=1
  - `line_valid`=0
  - `line_len`=0
  - `line_match`=0
  - `rd_data`=0
  - `overflow`=0
  - `timeout`=0
  - state IDLE
- Reset mid-line discards all buffered data.
- `rx_data_ready` is a combinational decode of state: 1 in IDLE, COLLECT and DISCARD.
- Terminator accepted in cycle N → `line_valid`, `line_len` and `line_match` are valid from cycle N+1.
- `line_ack` sampled in cycle M → `line_valid`=0 and `rx_data_ready`=1 in cycle M+1. A byte can be accepted in M+1.
- `rd_data` latency: one cycle after `rd_addr`.
- `overflow` is asserted in the cycle after the (MAX_LEN+1)th non-terminator byte is accepted.
- `timeout` is asserted one cycle after the counter equals the limit.
- Terminator and timeout in the same cycle: the terminator wins.

## Structure
- Shared package/header `uart_defs`:
  - ASCII_CR and ASCII_LF constants.
  - State encoding for uart_line_rx.
  - The default banner string, also used by the transmit-side sender.
- Sub-module `uart_line_buf`: MAX_LEN×8 simple dual-port buffer with one synchronous write port and one registered read port. Out-of-range zeroing is done in the parent.
- The FSM, counters and match logic live in `uart_line_rx`.

## Test plan
- Send "Hello Tang Nano 9K",0x0D,0x0A → `line_valid`=1, `line_len`=18, `line_match`=1. The LF is swallowed after `line_ack`. `rd_addr`=6 gives `rd_data`=0x54 ('T').
- Send "Hello Tang Nano 9" plus LF → `line_len`=17, `line_match`=0. Send "Hello Tang Nano 9KX" plus CR → `line_len`=19, `line_match`=0.
- Send 33 × 'A' then LF (MAX_LEN=32) → `overflow` pulses once after byte 33. No `line_valid`. The next line "ok",CR gives `line_len`=2.
- Send "ab", then idle for the timeout (TIMEOUT_MS reduced for sim) → one `timeout` pulse, state IDLE. A following "c",LF gives `line_len`=1 with `rd_data`[0]=0x63.
- Hold `line_ack`=0 for 100 cycles while `rx_data_valid`=1 → `rx_data_ready`=0 throughout, no byte lost. After ack, the pending byte is accepted on the next cycle.
- Deassert `rst_n` mid-line after "Hel" → all outputs take their reset values. "Hi",LF after release gives `line_len`=2, `line_match`=0.

Source files
------------

// File: rtl/uart_defs.sv
// uart_defs: shared constants for the board UART blocks.
// Line terminators, line receiver state encoding and the banner.
package uart_defs;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } line_st_e;

  localparam int BANNER_LEN = 18;
  localparam logic [BANNER_LEN*8-1:0] BANNER =
    "Hello Tang Nano 9K";

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_line_buf.sv
// uart_line_buf: line storage, one sync write port and
// one registered read port. Range gating is done by the user.
module uart_line_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // registered read port
  always_ff @(posedge clk) begin
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/uart_line_rx.sv
// uart_line_rx: assembles CR/LF terminated lines from uart_rx,
// compares against an expected string and holds them for readout.
module uart_line_rx
  import uart_defs::*;
#(
  parameter int CLK_FRE    = 27,
  parameter int TIMEOUT_MS = 1000,
  parameter int MAX_LEN    = 32,
  parameter int EXP_LEN    = 18,
  parameter logic [EXP_LEN*8-1:0] EXP_STR = BANNER
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_data_valid,
  output logic                       rx_data_ready,
  output logic                       line_valid,
  output logic [7:0]                 line_len,
  output logic                       line_match,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  input  logic                       line_ack,
  output logic                       overflow,
  output logic                       timeout
);

  localparam int AW = $clog2(MAX_LEN);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  localparam logic [7:0] EXP_B = 8'(EXP_LEN);
  localparam logic [31:0] LIMIT =
    32'(CLK_FRE * 1000 * TIMEOUT_MS);

  line_st_e    r_state, w_state_d;
  logic [7:0]  r_len, w_len_d;
  logic        r_mok, w_mok_d;
  logic        r_lmatch, w_lmatch_d;
  logic [31:0] r_cnt, w_cnt_d;
  logic        r_ovf, w_ovf_d;
  logic        r_to, w_to_d;
  logic        r_rd_in;
  logic        w_we;
  logic        w_acc;
  logic        w_term;
  logic        w_byte_ok;
  logic [7:0]  w_idx;
  logic [7:0]  w_buf_q;

  function automatic logic [7:0] exp_byte(input logic [7:0] i);
    if (int'(i) < EXP_LEN)
      return EXP_STR[(EXP_LEN-1-int'(i))*8 +: 8];
    return 8'h00;
  endfunction

  assign rx_data_ready = (r_state != ST_HOLD);
  assign line_valid    = (r_state == ST_HOLD);
  assign line_len      = r_len;
  assign line_match    = r_lmatch;
  assign overflow      = r_ovf;
  assign timeout       = r_to;
  assign rd_data       = r_rd_in ? w_buf_q : 8'h00;

  assign w_acc     = rx_data_valid && rx_data_ready;
  assign w_term    = is_term(rx_data);
  assign w_idx     = (r_state == ST_IDLE) ? 8'd0 : r_len;
  assign w_byte_ok = (w_idx < EXP_B) &&
                     (rx_data == exp_byte(w_idx));

  // next-state, length, match and pulse decode
  always_comb begin
    w_state_d  = r_state;
    w_len_d    = r_len;
    w_mok_d    = r_mok;
    w_lmatch_d = r_lmatch;
    w_cnt_d    = r_cnt;
    w_ovf_d    = 1'b0;
    w_to_d     = 1'b0;
    w_we       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_d = '0;
        if (w_acc && !w_term) begin
          w_we      = 1'b1;
          w_len_d   = 8'd1;
          w_mok_d   = w_byte_ok;
          w_state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (w_acc) begin
          w_cnt_d = '0;
          if (w_term) begin
            w_state_d  = ST_HOLD;
            w_lmatch_d = r_mok && (r_len == EXP_B);
          end else if (r_len < MAX_B) begin
            w_we    = 1'b1;
            w_len_d = r_len + 8'd1;
            w_mok_d = r_mok && w_byte_ok;
          end else begin
            w_ovf_d   = 1'b1;
            w_state_d = ST_DISCARD;
          end
        end else if (r_cnt == LIMIT) begin
          w_to_d    = 1'b1;
          w_state_d = ST_IDLE;
          w_len_d   = '0;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 32'd1;
        end
      end
      ST_DISCARD: begin
        if (w_acc) begin
          w_cnt_d = '0;
          if (w_term) begin
            w_state_d = ST_IDLE;
            w_len_d   = '0;
          end
        end else if (r_cnt == LIMIT) begin
          w_to_d    = 1'b1;
          w_state_d = ST_IDLE;
          w_len_d   = '0;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 32'd1;
        end
      end
      ST_HOLD: begin
        w_cnt_d = '0;
        if (line_ack) begin
          w_state_d  = ST_IDLE;
          w_len_d    = '0;
          w_lmatch_d = 1'b0;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
        w_len_d   = '0;
        w_cnt_d   = '0;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_len    <= '0;
      r_mok    <= 1'b0;
      r_lmatch <= 1'b0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_len    <= w_len_d;
      r_mok    <= w_mok_d;
      r_lmatch <= w_lmatch_d;
      r_cnt    <= w_cnt_d;
      r_ovf    <= w_ovf_d;
      r_to     <= w_to_d;
    end
  end

  // read range flag, aligned with the registered buffer read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_in <= 1'b0;
    else        r_rd_in <= (8'(rd_addr) < r_len);
  end

  uart_line_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_idx[AW-1:0]),
    .i_wdata (rx_data),
    .i_raddr (rd_addr),
    .o_rdata (w_buf_q)
  );

endmodule
